// File: rtl/byte_word_sequencer.sv
// byte_word_sequencer: assembles {msbyte, lsbyte} from two serial reads on one byte port,
// with a per-read ack timeout that aborts the sequence and pulses err.
module byte_word_sequencer #(
   parameter int AW      = 16,
   parameter int DW      = 8,
   parameter int TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [AW-1:0]   ms_addr,
   input  logic [AW-1:0]   ls_addr,
   output logic            busy,
   output logic            mem_req,
   output logic [AW-1:0]   mem_addr,
   input  logic            mem_ack,
   input  logic [DW-1:0]   mem_data,
   output logic [2*DW-1:0] word,
   output logic            word_valid,
   input  logic            word_ready,
   output logic            err
);
   typedef enum logic [1:0] {IDLE, RD_MS, RD_LS, DONE} state_t;
   state_t          r_state, w_next;
   logic [AW-1:0]   r_ls_addr, r_mem_addr;
   logic [DW-1:0]   r_hi;
   logic [2*DW-1:0] r_word;
   logic [7:0]      r_cnt;
   logic            r_err, w_rd, w_timeout;
   always_comb begin
      w_next    = r_state;
      w_rd      = (r_state == RD_MS) || (r_state == RD_LS);
      // an ack arriving on the limit cycle still completes the read
      w_timeout = w_rd && !mem_ack && (r_cnt == 8'(TIMEOUT - 1));
      case (r_state)
         IDLE:    w_next = start ? RD_MS : IDLE;
         RD_MS:   w_next = mem_ack ? RD_LS : (w_timeout ? IDLE : RD_MS);
         RD_LS:   w_next = mem_ack ? DONE : (w_timeout ? IDLE : RD_LS);
         default: w_next = word_ready ? IDLE : DONE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_ls_addr  <= '0;
         r_mem_addr <= '0;
         r_hi       <= '0;
         r_word     <= '0;
         r_cnt      <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_next;
         r_err   <= w_timeout;
         r_cnt   <= (w_rd && !mem_ack) ? r_cnt + 8'd1 : 8'd0;
         if (r_state == IDLE && start) begin
            r_mem_addr <= ms_addr;
            r_ls_addr  <= ls_addr;
         end
         if (r_state == RD_MS && mem_ack) begin
            r_hi       <= mem_data;
            r_mem_addr <= r_ls_addr;
         end
         // word only updates on a full two-byte completion
         if (r_state == RD_LS && mem_ack) r_word <= {r_hi, mem_data};
      end
   end
   assign busy       = (r_state != IDLE);
   assign mem_req    = w_rd;
   assign mem_addr   = r_mem_addr;
   assign word       = r_word;
   assign word_valid = (r_state == DONE);
   assign err        = r_err;
endmodule
